// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: sequences a kernel-weight load from a valid/ready source into a
// weight store.
// - Each accepted weight is written one cycle later at the next counter address.
// - The final write coincides with a one-cycle o_done pulse.
// - o_loaded stays high until the next accepted start.
// Optional feature: define WEIGHT_CSUM_EN to add o_csum, the modulo-256 sum of the
// weights accepted since the last accepted start.
module weight_load_ctrl #(
  parameter int unsigned N_W = 25
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_w_valid,
  input  logic [7:0] i_w,
  output logic       o_w_ready,
  output logic       o_wr_en,
  output logic [4:0] o_addr,
  output logic [7:0] o_w,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_loaded
`ifdef WEIGHT_CSUM_EN
  ,
  output logic [7:0] o_csum
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [4:0] LastIdx = 5'(N_W - 1);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       wr_en_q, wr_en_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] w_q, w_d;
  logic       done_q, done_d;
  logic       loaded_q, loaded_d;
  logic       start_acc;
  logic       transfer;

  // Ready is a pure state decode so the source may wait on it before raising valid
  assign o_w_ready = (state_q == StLoad);
  assign o_busy    = (state_q == StLoad);
  assign o_wr_en   = wr_en_q;
  assign o_addr    = addr_q;
  assign o_w       = w_q;
  assign o_done    = done_q;
  assign o_loaded  = loaded_q;

  // Abort in LOAD suppresses any transfer offered in the same cycle
  assign start_acc = (state_q == StIdle) && i_start && !i_abort;
  assign transfer  = (state_q == StLoad) && i_w_valid && !i_abort;

  // Next-state, counter and registered write-port outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    w_d      = w_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          state_d  = StLoad;
          cnt_d    = 5'd0;
          loaded_d = 1'b0;
        end
      end
      StLoad: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (transfer) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          w_d     = i_w;
          cnt_d   = cnt_q + 5'd1;
          // Last weight: DONE, o_done and o_loaded all land with the final strobe
          if (cnt_q == LastIdx) begin
            state_d  = StDone;
            done_d   = 1'b1;
            loaded_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      wr_en_q  <= 1'b0;
      addr_q   <= 5'd0;
      w_q      <= 8'd0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      w_q      <= w_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
    end
  end

`ifdef WEIGHT_CSUM_EN
  logic [7:0] csum_q, csum_d;

  assign o_csum = csum_q;

  // Running checksum: cleared by an accepted start, accumulates each transfer
  always_comb begin
    csum_d = csum_q;
    if (start_acc) begin
      csum_d = 8'd0;
    end else if (transfer) begin
      csum_d = csum_q + i_w;
    end
  end

  // Checksum register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csum_q <= 8'd0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: scenario tasks drive the weight source and push expected writes
// to a scoreboard; a negedge monitor pops and compares every write strobe.
module tb_weight_load_ctrl;

  localparam int NW = 25;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic       i_w_valid = 1'b0;
  logic [7:0] i_w = 8'd0;
  logic       o_w_ready;
  logic       o_wr_en;
  logic [4:0] o_addr;
  logic [7:0] o_w;
  logic       o_busy;
  logic       o_done;
  logic       o_loaded;
`ifdef WEIGHT_CSUM_EN
  logic [7:0] o_csum;
`endif

  weight_load_ctrl #(.N_W(NW)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_w_valid (i_w_valid),
    .i_w       (i_w),
    .o_w_ready (o_w_ready),
    .o_wr_en   (o_wr_en),
    .o_addr    (o_addr),
    .o_w       (o_w),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_loaded  (o_loaded)
`ifdef WEIGHT_CSUM_EN
    ,
    .o_csum    (o_csum)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  logic [4:0] exp_addr = 5'd0;
  logic [7:0] exp_csum = 8'd0;

  // Scoreboard monitor: every strobe must match the oldest expected write
  always @(negedge i_clk) begin
    if (o_wr_en === 1'b1) begin
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%0d expected no write", o_addr, o_w);
      end else begin
        mon_e = sb.pop_front();
        if (o_addr !== mon_e.addr || o_w !== mon_e.data) begin
          errors++;
          $display("FAIL write_data got addr=%0d data=%0d expected addr=%0d data=%0d",
                   o_addr, o_w, mon_e.addr, mon_e.data);
        end
      end
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      checks++;
      if (o_wr_en !== 1'b1 || o_addr !== 5'(NW - 1)) begin
        errors++;
        $display("FAIL done_with_last_write got wr_en=%b addr=%0d expected wr_en=1 addr=%0d",
                 o_wr_en, o_addr, NW - 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    exp_t t;
    t.addr = exp_addr;
    t.data = d;
    sb.push_back(t);
    exp_addr = exp_addr + 5'd1;
    exp_csum = exp_csum + d;
  endtask

  task automatic start_seq();
    i_start = 1'b1;
    cyc();
    i_start  = 1'b0;
    exp_addr = 5'd0;
    exp_csum = 8'd0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({o_busy, o_w_ready, o_wr_en, o_done, o_loaded, o_addr, o_w} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b rdy=%b wr=%b done=%b ld=%b addr=%0d w=%0d expected all 0",
               o_busy, o_w_ready, o_wr_en, o_done, o_loaded, o_addr, o_w);
    end
`ifdef WEIGHT_CSUM_EN
    checks++;
    if (o_csum !== 8'd0) begin
      errors++;
      $display("FAIL reset_csum got %0d expected 0", o_csum);
    end
`endif
    cyc();
    i_rst_n = 1'b1;
    cyc();
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_w_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got busy=%b rdy=%b expected 0 0", o_busy, o_w_ready);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    wr_cnt   = 0;
    done_cnt = 0;
    start_seq();
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_w_ready, o_loaded} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_load_entry got busy=%b rdy=%b ld=%b expected 1 1 0",
               o_busy, o_w_ready, o_loaded);
    end
    cyc();
    for (int k = 0; k < NW; k++) begin
      i_w_valid = 1'b1;
      i_w       = 8'(k + 1);
      push(8'(k + 1));
      cyc();
      checks++;
      if (o_wr_en !== 1'b1) begin
        errors++;
        $display("FAIL b2b_consecutive got wr_en=%b expected 1 at k=%0d", o_wr_en, k);
      end
    end
    i_w_valid = 1'b0;
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_done, o_wr_en, o_loaded} !== 3'b111 || o_addr !== 5'd24) begin
      errors++;
      $display("FAIL b2b_done_cycle got done=%b wr=%b ld=%b addr=%0d expected 1 1 1 24",
               o_done, o_wr_en, o_loaded, o_addr);
    end
`ifdef WEIGHT_CSUM_EN
    checks++;
    if (o_csum !== 8'h45) begin
      errors++;
      $display("FAIL b2b_csum got %0h expected 45", o_csum);
    end
`endif
    cyc();
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_wr_en, o_loaded} !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_after_done got busy=%b done=%b wr=%b ld=%b expected 0 0 0 1",
               o_busy, o_done, o_wr_en, o_loaded);
    end
    checks++;
    if (wr_cnt != NW || done_cnt != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_counts got writes=%0d dones=%0d pending=%0d expected %0d 1 0",
               wr_cnt, done_cnt, sb.size(), NW);
    end
    cyc();
  endtask

  task automatic test_toggle();
    int n = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    start_seq();
    for (int i = 0; n < NW; i++) begin
      i_w_valid = (i % 2 == 0);
      i_w       = 8'($urandom);
      if (i_w_valid) begin
        push(i_w);
        n++;
      end
      @(negedge i_clk);
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL toggle_busy got %b expected 1 at cycle %0d", o_busy, i);
      end
      cyc();
    end
    i_w_valid = 1'b0;
    @(negedge i_clk);
    #1;
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL toggle_done got %b expected 1", o_done);
    end
`ifdef WEIGHT_CSUM_EN
    checks++;
    if (o_csum !== exp_csum) begin
      errors++;
      $display("FAIL toggle_csum got %0h expected %0h", o_csum, exp_csum);
    end
`endif
    cyc();
    checks++;
    if (wr_cnt != NW || done_cnt != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_counts got writes=%0d dones=%0d pending=%0d expected %0d 1 0",
               wr_cnt, done_cnt, sb.size(), NW);
    end
  endtask

  task automatic test_abort();
    wr_cnt   = 0;
    done_cnt = 0;
    start_seq();
    for (int k = 0; k < 10; k++) begin
      i_w_valid = 1'b1;
      i_w       = 8'(100 + k);
      push(8'(100 + k));
      cyc();
    end
    i_w     = 8'd111;
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    i_w     = 8'd112;
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_w_ready, o_wr_en, o_loaded, o_done} !== 5'd0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b rdy=%b wr=%b ld=%b done=%b expected all 0",
               o_busy, o_w_ready, o_wr_en, o_loaded, o_done);
    end
    cyc();
    cyc();
    i_w_valid = 1'b0;
    checks++;
    if (wr_cnt != 10 || done_cnt != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL abort_counts got writes=%0d dones=%0d pending=%0d expected 10 0 0",
               wr_cnt, done_cnt, sb.size());
    end
    start_seq();
    for (int k = 0; k < 3; k++) begin
      i_w_valid = 1'b1;
      i_w       = 8'(50 + k);
      push(8'(50 + k));
      cyc();
    end
    i_w_valid = 1'b0;
    @(negedge i_clk);
    #1;
    checks++;
    if (wr_cnt != 13 || sb.size() != 0 || o_loaded !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart got writes=%0d pending=%0d ld=%b busy=%b expected 13 0 0 1",
               wr_cnt, sb.size(), o_loaded, o_busy);
    end
`ifdef WEIGHT_CSUM_EN
    checks++;
    if (o_csum !== 8'd153) begin
      errors++;
      $display("FAIL restart_csum got %0d expected 153", o_csum);
    end
`endif
    cyc();
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    wr_cnt   = 0;
    done_cnt = 0;
    start_seq();
    for (int k = 0; k < NW; k++) begin
      i_w_valid = 1'b1;
      i_w       = 8'(k * 7);
      i_start   = (k == 5);
      push(8'(k * 7));
      cyc();
      i_start = 1'b0;
    end
    i_start = 1'b1;
    i_w     = 8'hAA;
    @(negedge i_clk);
    #1;
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL ign_done got %b expected 1", o_done);
    end
    cyc();
    i_start = 1'b0;
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_w_ready, o_loaded} !== 3'b001) begin
      errors++;
      $display("FAIL ign_idle got busy=%b rdy=%b ld=%b expected 0 0 1", o_busy, o_w_ready, o_loaded);
    end
`ifdef WEIGHT_CSUM_EN
    checks++;
    if (o_csum !== exp_csum) begin
      errors++;
      $display("FAIL ign_csum got %0h expected %0h", o_csum, exp_csum);
    end
`endif
    cyc();
    i_w_valid = 1'b0;
    checks++;
    if (wr_cnt != NW || done_cnt != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL ign_counts got writes=%0d dones=%0d pending=%0d expected %0d 1 0",
               wr_cnt, done_cnt, sb.size(), NW);
    end
  endtask

  task automatic test_reset_mid();
    wr_cnt = 0;
    start_seq();
    for (int k = 0; k < 12; k++) begin
      i_w_valid = 1'b1;
      i_w       = 8'(k + 31);
      push(8'(k + 31));
      cyc();
    end
    // The 13th weight is accepted, but reset lands before its strobe is sampled
    i_w = 8'd99;
    @(negedge i_clk);
    cyc();
    checks++;
    if (o_wr_en !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got wr=%b busy=%b expected 1 1", o_wr_en, o_busy);
    end
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_w_ready, o_wr_en, o_done, o_loaded, o_addr, o_w} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid_async got busy=%b rdy=%b wr=%b done=%b ld=%b addr=%0d w=%0d expected all 0",
               o_busy, o_w_ready, o_wr_en, o_done, o_loaded, o_addr, o_w);
    end
`ifdef WEIGHT_CSUM_EN
    checks++;
    if (o_csum !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_csum got %0d expected 0", o_csum);
    end
`endif
    cyc();
    cyc();
    i_rst_n = 1'b1;
    cyc();
    cyc();
    @(negedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after got busy=%b wr=%b expected 0 0", o_busy, o_wr_en);
    end
    i_w_valid = 1'b0;
    checks++;
    if (wr_cnt != 12 || sb.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_counts got writes=%0d pending=%0d expected 12 0", wr_cnt, sb.size());
    end
    cyc();
  endtask

  task automatic test_start_abort_idle();
    int wr0 = wr_cnt;
    i_start   = 1'b1;
    i_abort   = 1'b1;
    i_w_valid = 1'b1;
    cyc();
    i_start = 1'b0;
    i_abort = 1'b0;
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_w_ready} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort_idle got busy=%b rdy=%b expected 0 0", o_busy, o_w_ready);
    end
    cyc();
    @(negedge i_clk);
    #1;
    checks++;
    if (o_wr_en !== 1'b0 || wr_cnt != wr0) begin
      errors++;
      $display("FAIL start_abort_nowrite got wr=%b writes=%0d expected 0 %0d", o_wr_en, wr_cnt, wr0);
    end
    i_w_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_start_abort_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
